// File: rtl/sram_ctrl.sv
// Asynchronous-SRAM controller: valid/ready request port, wait-stated read/write
// cycles, byte/half/word lanes with load extension and a one-cycle response pulse.
module sram_ctrl #(
    parameter int ADDR_W     = 20,
    parameter int READ_WAIT  = 1,
    parameter int WRITE_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_off,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_be_n,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_data_out,
    output logic              sram_data_oe,
    input  logic [31:0]       sram_data_in
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WSETUP,
        WPULSE,
        WHOLD
    } state_e;

    localparam int MAXW = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
    localparam int CW   = (MAXW > 1) ? $clog2(MAXW) : 1;
    localparam logic [CW-1:0] RD_LAST = CW'(READ_WAIT - 1);
    localparam logic [CW-1:0] WR_LAST = CW'(WRITE_WAIT - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [1:0]        off_q, off_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              rvalid_q, rvalid_d;
    logic              rerr_q, rerr_d;
    logic [31:0]       rdata_q, rdata_d;

    logic        accept;
    logic        misalign;
    logic        rd_done;
    logic [3:0]  lane_be;
    logic [31:0] rep_data;
    logic [31:0] lane_sh;
    logic [31:0] load_ext;

    assign accept   = req_valid && (state_q == IDLE);
    assign misalign = ((req_size == 2'd1) && req_off[0]) ||
                      (req_size[1] && (req_off != 2'd0));
    assign rd_done  = (state_q == READ) && (cnt_q == RD_LAST);

    // Request decode: active-low lane mask and store data replicated per size
    always_comb begin
        unique case (1'b1)
            req_size == 2'd0: begin
                lane_be  = ~(4'b0001 << req_off);
                rep_data = {4{req_wdata[7:0]}};
            end
            req_size == 2'd1: begin
                lane_be  = ~(4'b0011 << req_off);
                rep_data = {2{req_wdata[15:0]}};
            end
            default: begin
                lane_be  = 4'b0000;
                rep_data = req_wdata;
            end
        endcase
    end

    always_comb begin
        lane_sh = sram_data_in >> {off_q, 3'b000};
        unique case (1'b1)
            size_q == 2'd0:
                load_ext = {{24{~uns_q & lane_sh[7]}}, lane_sh[7:0]};
            size_q == 2'd1:
                load_ext = {{16{~uns_q & lane_sh[15]}}, lane_sh[15:0]};
            default:
                load_ext = lane_sh;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept && !misalign) begin
                    state_d = req_we ? WSETUP : READ;
                end
            end
            READ: begin
                if (cnt_q == RD_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WSETUP: begin
                state_d = WPULSE;
                cnt_d   = '0;
            end
            WPULSE: begin
                if (cnt_q == WR_LAST) begin
                    state_d = WHOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WHOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request capture and response generation
    always_comb begin
        addr_d   = addr_q;
        be_d     = be_q;
        off_d    = off_q;
        size_d   = size_q;
        uns_d    = uns_q;
        wdata_d  = wdata_q;
        rvalid_d = 1'b0;
        rerr_d   = 1'b0;
        rdata_d  = rdata_q;
        if (accept) begin
            rvalid_d = misalign;
            rerr_d   = misalign;
            if (!misalign) begin
                addr_d  = req_addr;
                be_d    = lane_be;
                off_d   = req_off;
                size_d  = req_size;
                uns_d   = req_unsigned;
                wdata_d = rep_data;
            end
        end
        if (rd_done) begin
            rvalid_d = 1'b1;
            rdata_d  = load_ext;
        end
        if (state_q == WHOLD) begin
            rvalid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            be_q     <= 4'b1111;
            off_q    <= 2'd0;
            size_q   <= 2'd0;
            uns_q    <= 1'b0;
            wdata_q  <= 32'd0;
            rvalid_q <= 1'b0;
            rerr_q   <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            addr_q   <= addr_d;
            be_q     <= be_d;
            off_q    <= off_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            wdata_q  <= wdata_d;
            rvalid_q <= rvalid_d;
            rerr_q   <= rerr_d;
            rdata_q  <= rdata_d;
        end
    end

    // Strobes decode from state alone so an async reset releases them at once
    always_comb begin
        req_ready     = (state_q == IDLE);
        sram_ce_n     = !((state_q == READ) || (state_q == WPULSE));
        sram_oe_n     = (state_q != READ);
        sram_we_n     = (state_q != WPULSE);
        sram_be_n     = (state_q == IDLE) ? 4'b1111 : be_q;
        sram_addr     = addr_q;
        sram_data_out = wdata_q;
        sram_data_oe  = (state_q == WSETUP) || (state_q == WPULSE) ||
                        (state_q == WHOLD);
        resp_valid    = rvalid_q;
        resp_err      = rerr_q;
        resp_rdata    = rdata_q;
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Randomized bench for sram_ctrl: byte-level memory reference model,
// SRAM pad model driven by the strobes, and protocol monitors.
module tb_sram_ctrl;

    localparam int AW = 20;
    localparam int RW = 3;
    localparam int WW = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [1:0]    req_off;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic          resp_err;
    logic [31:0]   resp_rdata;
    logic          sram_ce_n;
    logic          sram_oe_n;
    logic          sram_we_n;
    logic [3:0]    sram_be_n;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_data_out;
    logic          sram_data_oe;
    logic [31:0]   sram_data_in;

    always #5 clk = ~clk;

    sram_ctrl #(
        .ADDR_W    (AW),
        .READ_WAIT (RW),
        .WRITE_WAIT(WW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_off      (req_off),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_rdata   (resp_rdata),
        .sram_ce_n    (sram_ce_n),
        .sram_oe_n    (sram_oe_n),
        .sram_we_n    (sram_we_n),
        .sram_be_n    (sram_be_n),
        .sram_addr    (sram_addr),
        .sram_data_out(sram_data_out),
        .sram_data_oe (sram_data_oe),
        .sram_data_in (sram_data_in)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return (32'h9E3779B9 * 32'(i + 1)) ^ 32'h00C0FFEE;
    endfunction

    // Reference memory (request level) and pad-side SRAM (strobe level)
    logic [31:0] rmem [64];
    logic [31:0] smem [64];
    logic        mem_ready = 1'b0;

    int          oe_low = 0;
    int          we_low = 0;
    int          ce_low = 0;
    int          doe_cnt = 0;
    logic [3:0]  be_seen = 4'hF;
    logic [31:0] dout_seen = 32'd0;

    assign sram_data_in = (!sram_ce_n && !sram_oe_n) ?
                          smem[sram_addr[5:0]] : 32'h5A5A0F0F;

    always @(negedge clk) begin
        if (rst) begin
            if (!mem_ready) begin
                for (int i = 0; i < 64; i++) smem[i] = init_word(i);
                mem_ready = 1'b1;
            end
        end else begin
            if (!sram_oe_n) oe_low++;
            if (!sram_we_n) we_low++;
            if (!sram_ce_n) begin
                ce_low++;
                be_seen = sram_be_n;
            end
            if (sram_data_oe) begin
                doe_cnt++;
                dout_seen = sram_data_out;
            end
            if (!sram_ce_n && !sram_we_n) begin
                for (int l = 0; l < 4; l++)
                    if (!sram_be_n[l])
                        smem[sram_addr[5:0]][8*l +: 8] = sram_data_out[8*l +: 8];
            end
            check("oe_we_excl", 32'(!sram_oe_n && !sram_we_n), 32'd0);
            check("doe_while_oe", 32'(sram_data_oe && !sram_oe_n), 32'd0);
        end
    end

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_read(input logic [AW-1:0] a,
        input logic [1:0] off, input logic [1:0] sz, input logic uns);
        logic [31:0] w, r;
        int nb, o;
        nb = nbytes(sz);
        o  = int'(off);
        w  = rmem[a[5:0]];
        r  = 32'd0;
        for (int k = 0; k < nb; k++) r[8*k +: 8] = w[8*(o + k) +: 8];
        if (!uns && nb < 4 && r[8*nb-1])
            for (int k = nb; k < 4; k++) r[8*k +: 8] = 8'hFF;
        return r;
    endfunction

    logic [31:0] last_rd = 32'd0;
    logic        rd_known = 1'b1;

    task automatic do_req(input logic we, input logic [AW-1:0] a,
                          input logic [1:0] off, input logic [1:0] sz,
                          input logic uns, input logic [31:0] wd);
        int nb, o, lat, exp_lat, oe0, we0, ce0, doe0;
        logic mis;
        logic [3:0] ebe;
        logic [31:0] edout, erd, w;
        nb  = nbytes(sz);
        o   = int'(off);
        mis = (o % nb) != 0;
        ebe = 4'hF;
        edout = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if (i >= o && i < o + nb) ebe[i] = 1'b0;
            edout[8*i +: 8] = wd[8*(i % nb) +: 8];
        end
        erd = mis ? 32'd0 : model_read(a, off, sz, uns);
        exp_lat = mis ? 0 : (we ? WW + 2 : RW);
        oe0 = oe_low; we0 = we_low; ce0 = ce_low; doe0 = doe_cnt;

        req_we = we; req_addr = a; req_off = off;
        req_size = sz; req_unsigned = uns; req_wdata = wd;
        req_valid = 1'b1;
        check("ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr = AW'($urandom); req_wdata = $urandom;
        req_off = 2'($urandom); req_size = 2'($urandom);

        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = i;
                break;
            end
        end
        check("resp_latency", 32'(lat), 32'(exp_lat));
        if (lat >= 0) begin
            check("resp_err", 32'(resp_err), 32'(mis));
            if (mis) begin
                check("mis_no_strobe", 32'(ce_low - ce0), 32'd0);
                if (!we) rd_known = 1'b0;
            end else if (we) begin
                check("wr_we_cycles", 32'(we_low - we0), 32'(WW));
                check("wr_no_oe", 32'(oe_low - oe0), 32'd0);
                check("wr_doe_cycles", 32'(doe_cnt - doe0), 32'(WW + 2));
                check("wr_be", 32'(be_seen), 32'(ebe));
                check("wr_dout", dout_seen, edout);
                if (rd_known) check("rdata_hold", resp_rdata, last_rd);
                w = rmem[a[5:0]];
                for (int k = 0; k < nb; k++) w[8*(o + k) +: 8] = wd[8*k +: 8];
                rmem[a[5:0]] = w;
            end else begin
                check("rd_oe_cycles", 32'(oe_low - oe0), 32'(RW));
                check("rd_no_we", 32'(we_low - we0), 32'd0);
                check("rd_be", 32'(be_seen), 32'(ebe));
                check("rd_data", resp_rdata, erd);
                last_rd = erd;
                rd_known = 1'b1;
            end
        end
        @(negedge clk);
        check("single_pulse", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        int t[2];
        logic [31:0] rd[2];
        int got, oe0, rv;
        logic found;

        for (int i = 0; i < 64; i++) rmem[i] = init_word(i);
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_off = 2'd0;
        req_size = 2'd0; req_unsigned = 1'b0; req_wdata = 32'd0;
        #2;
        check("rst_ce", 32'(sram_ce_n), 32'd1);
        check("rst_oe", 32'(sram_oe_n), 32'd1);
        check("rst_we", 32'(sram_we_n), 32'd1);
        check("rst_be", 32'(sram_be_n), 32'hF);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_dout", sram_data_out, 32'd0);
        check("rst_doe", 32'(sram_data_oe), 32'd0);
        check("rst_rvalid", 32'(resp_valid), 32'd0);
        check("rst_rerr", 32'(resp_err), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_req(1'b1, AW'(32'h10), 2'd0, 2'd2, 1'b0, 32'hDEADBEEF);
        do_req(1'b0, AW'(32'h10), 2'd3, 2'd0, 1'b0, 32'd0);
        check("dir_byte_signed", resp_rdata, 32'hFFFFFFDE);
        check("dir_byte_be", 32'(be_seen), 32'h7);
        do_req(1'b0, AW'(32'h10), 2'd2, 2'd1, 1'b1, 32'd0);
        check("dir_half_unsigned", resp_rdata, 32'h0000DEAD);
        do_req(1'b1, AW'(32'h10), 2'd1, 2'd0, 1'b0, 32'h000000A5);
        check("dir_byte_rep", dout_seen, 32'hA5A5A5A5);
        check("dir_byte_wbe", 32'(be_seen), 32'hD);
        do_req(1'b0, AW'(32'h10), 2'd1, 2'd1, 1'b0, 32'd0);

        for (int n = 0; n < 80; n++) begin
            do_req(1'($urandom), AW'(32'h10 + $urandom_range(0, 15)),
                   2'($urandom), 2'($urandom), 1'($urandom), $urandom);
        end

        // Two reads back to back; second held valid until it is taken
        oe0 = oe_low;
        got = 0;
        t[0] = -1; t[1] = -1;
        rd[0] = 32'd0; rd[1] = 32'd0;
        req_we = 1'b0; req_addr = AW'(32'h12); req_off = 2'd0;
        req_size = 2'd2; req_unsigned = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_addr = AW'(32'h13); req_off = 2'd2;
        req_size = 2'd0; req_unsigned = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (resp_valid && got < 2) begin
                t[got] = i;
                rd[got] = resp_rdata;
                got++;
                if (got == 1) check("b2b_ready", 32'(req_ready), 32'd1);
            end
            if (got == 1 && i == t[0] + 1) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        check("b2b_first_lat", 32'(t[0]), 32'(RW));
        check("b2b_second_lat", 32'(t[1]), 32'(2 * RW + 1));
        check("b2b_first_data", rd[0],
              model_read(AW'(32'h12), 2'd0, 2'd2, 1'b0));
        check("b2b_second_data", rd[1],
              model_read(AW'(32'h13), 2'd2, 2'd0, 1'b1));
        check("b2b_oe_cycles", 32'(oe_low - oe0), 32'(2 * RW));
        @(negedge clk);

        // Reset while the write pulse is active
        req_we = 1'b1; req_addr = AW'(32'h3FF); req_off = 2'd0;
        req_size = 2'd2; req_wdata = 32'h12345678;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!sram_we_n) begin
                found = 1'b1;
                break;
            end
        end
        check("rst_reach_wpulse", 32'(found), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_we", 32'(sram_we_n), 32'd1);
        check("rst_mid_ce", 32'(sram_ce_n), 32'd1);
        check("rst_mid_doe", 32'(sram_data_oe), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rv = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (resp_valid) rv++;
        end
        check("rst_ready_after", 32'(req_ready), 32'd1);
        check("rst_no_resp", 32'(rv), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
